// File: rtl/tinyqv_sys_pkg.sv
// tinyQV system-control shared definitions: register offsets,
// UART status bit positions and the UART shifter state encoding.
package tinyqv_sys_pkg;

  localparam logic [3:0] SYS_GPIO_SEL    = 4'h3;
  localparam logic [3:0] SYS_UART_DATA   = 4'h6;
  localparam logic [3:0] SYS_UART_STATUS = 4'h7;
  localparam logic [3:0] SYS_TIME_DIV    = 4'h8;
  localparam logic [3:0] SYS_DEBUG       = 4'hC;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_LVL_LSB = 8;

  typedef enum logic [1:0] {
    U_IDLE,
    U_START,
    U_DATA,
    U_STOP
  } uart_state_t;

endpackage

// File: rtl/tinyqv_sys_fifo.sv
// Small synchronous byte FIFO for the debug UART.
// Fullness is judged before a same-cycle pop.
module tinyqv_sys_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] MASK = AW'(DEPTH - 1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [LW-1:0] r_lvl;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_lvl == LW'(DEPTH));
  assign o_empty   = (r_lvl == '0);
  assign o_level   = r_lvl;
  assign o_data    = r_mem[r_rp];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push_ok) r_wp <= (r_wp + 1'b1) & MASK;
      if (w_pop_ok)  r_rp <= (r_rp + 1'b1) & MASK;
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_lvl <= r_lvl + 1'b1;
        2'b01:   r_lvl <= r_lvl - 1'b1;
        default: r_lvl <= r_lvl;
      endcase
    end
  end

endmodule

// File: rtl/tinyqv_sys_ctrl.sv
// tinyQV system control: register decode, GPIO select, tick, debug UART.
// Define TINYQV_SYS_UART_FIFO_EN to put a byte FIFO ahead of the UART.
module tinyqv_sys_ctrl
  import tinyqv_sys_pkg::*;
#(
  parameter int               CLOCK_MHZ  = 14,
  parameter int               BIT_RATE   = 1_000_000,
  parameter int               FIFO_DEPTH = 4,
  parameter int               SEL_W      = 2,
  parameter logic [SEL_W-1:0] SEL_RST    = 2'b10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [3:0]       addr,
  input  logic [31:0]      data_in,
  input  logic [1:0]       data_write_n,
  input  logic [1:0]       data_read_n,
  output logic [31:0]      data_out,
  output logic             data_ready,
  output logic             uart_txd,
  output logic             time_pulse,
  output logic [SEL_W-1:0] gpio_out_sel,
  output logic             debug_register_data
);
  localparam int BAUD_DIV = CLOCK_MHZ * 1_000_000 / BIT_RATE;
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [SEL_W-1:0] r_gpio;
  logic             r_dbg;
  logic [7:0]       r_div;
  logic [7:0]       r_cnt;
  logic             r_ovf;

  uart_state_t      r_state, w_state_d;
  logic [BW-1:0]    r_baud, w_baud_d;
  logic [2:0]       r_bit, w_bit_d;
  logic [7:0]       r_shift, w_shift_d;
  logic             r_txd, w_txd_d;

  logic             w_wr;
  logic             w_wr_gpio, w_wr_data, w_wr_stat;
  logic             w_wr_div, w_wr_dbg;
  logic             w_avail, w_drop, w_busy, w_full, w_pop;
  logic [7:0]       w_load;
  logic [LW-1:0]    w_level;
  logic             w_baud_last;
  logic             w_unused;

  assign w_wr      = sel && (data_write_n != 2'b11);
  assign w_wr_gpio = w_wr && (addr == SYS_GPIO_SEL);
  assign w_wr_data = w_wr && (addr == SYS_UART_DATA);
  assign w_wr_stat = w_wr && (addr == SYS_UART_STATUS);
  assign w_wr_div  = w_wr && (addr == SYS_TIME_DIV);
  assign w_wr_dbg  = w_wr && (addr == SYS_DEBUG);

  assign data_ready          = 1'b1;
  assign uart_txd            = r_txd;
  assign time_pulse          = (r_cnt == r_div);
  assign gpio_out_sel        = r_gpio;
  assign debug_register_data = r_dbg;
  assign w_unused = &{1'b0, data_in[31:8], data_read_n, w_pop};

`ifdef TINYQV_SYS_UART_FIFO_EN
  logic w_fifo_empty;

  tinyqv_sys_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_wr_data),
    .i_data  (data_in[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_load),
    .o_full  (w_full),
    .o_empty (w_fifo_empty),
    .o_level (w_level)
  );

  assign w_avail = !w_fifo_empty;
  assign w_drop  = w_wr_data && w_full;
  assign w_busy  = !w_fifo_empty || (r_state != U_IDLE);
`else
  // Without a FIFO the write data loads the shifter directly.
  assign w_avail = w_wr_data && (r_state == U_IDLE);
  assign w_load  = data_in[7:0];
  assign w_drop  = w_wr_data && (r_state != U_IDLE);
  assign w_busy  = (r_state != U_IDLE);
  assign w_full  = w_busy;
  assign w_level = {{(LW-1){1'b0}}, w_busy};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gpio <= SEL_RST;
      r_dbg  <= 1'b0;
      r_div  <= 8'(CLOCK_MHZ - 1);
      r_cnt  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_wr_gpio) r_gpio <= data_in[7:8-SEL_W];
      if (w_wr_dbg)  r_dbg  <= data_in[0];
      if (w_wr_div) begin
        r_div <= data_in[7:0];
        r_cnt <= '0;
      end else if (time_pulse) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_wr_stat && data_in[ST_OVF])
        r_ovf <= 1'b0;
    end
  end

  assign w_baud_last = (r_baud == BW'(BAUD_DIV - 1));

  always_comb begin
    w_state_d = r_state;
    w_baud_d  = r_baud;
    w_bit_d   = r_bit;
    w_shift_d = r_shift;
    w_pop     = 1'b0;
    unique case (r_state)
      U_IDLE: begin
        if (w_avail) begin
          w_pop     = 1'b1;
          w_state_d = U_START;
          w_baud_d  = '0;
          w_shift_d = w_load;
        end
      end
      U_START: begin
        if (w_baud_last) begin
          w_state_d = U_DATA;
          w_baud_d  = '0;
          w_bit_d   = '0;
        end else begin
          w_baud_d = r_baud + 1'b1;
        end
      end
      U_DATA: begin
        if (w_baud_last) begin
          w_baud_d  = '0;
          w_shift_d = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_d = U_STOP;
          else               w_bit_d   = r_bit + 1'b1;
        end else begin
          w_baud_d = r_baud + 1'b1;
        end
      end
      U_STOP: begin
        if (w_baud_last) begin
          w_baud_d = '0;
          // Chain straight into the next frame when more data waits.
          if (w_avail) begin
            w_pop     = 1'b1;
            w_state_d = U_START;
            w_shift_d = w_load;
          end else begin
            w_state_d = U_IDLE;
          end
        end else begin
          w_baud_d = r_baud + 1'b1;
        end
      end
      default: w_state_d = U_IDLE;
    endcase
    unique case (w_state_d)
      U_START: w_txd_d = 1'b0;
      U_DATA:  w_txd_d = w_shift_d[0];
      default: w_txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= U_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txd   <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_baud  <= w_baud_d;
      r_bit   <= w_bit_d;
      r_shift <= w_shift_d;
      r_txd   <= w_txd_d;
    end
  end

  always_comb begin
    data_out = '0;
    if (sel) begin
      case (addr)
        SYS_GPIO_SEL:  data_out[7:8-SEL_W] = r_gpio;
        SYS_UART_DATA: data_out = '0;
        SYS_UART_STATUS: begin
          data_out[ST_BUSY]           = w_busy;
          data_out[ST_FULL]           = w_full;
          data_out[ST_OVF]            = r_ovf;
          data_out[ST_LVL_LSB +: 8]   = 8'(w_level);
        end
        SYS_TIME_DIV:  data_out[7:0] = r_div;
        SYS_DEBUG:     data_out[0] = r_dbg;
        default:       data_out = '1;
      endcase
    end
  end

endmodule
